// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle between the execute stage and the sequential divider.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             kill;
    logic             sign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, kill, sign, a, b,
        input  ready, done, quotient, remainder
    );

    modport slave (
        input  start, kill, sign, a, b,
        output ready, done, quotient, remainder
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider producing RISC-V DIV/DIVU/REM/REMU quotient and remainder,
// one quotient bit per clock, with start/ready/done handshake and kill.
module seq_divider #(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN  = ONE << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic               special_q, special_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return (~x) + ONE;
    endfunction

    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH:0]   rem_ext_c;
    logic [WIDTH:0]   diff_c;
    logic             ge_c;
    logic [WIDTH-1:0] quo_raw_c;
    logic [WIDTH-1:0] rem_raw_c;

    // Operand magnitudes and one restoring step; the carry-out bit keeps the compare exact.
    always_comb begin
        a_mag_c   = (bus.sign && bus.a[WIDTH-1]) ? neg(bus.a) : bus.a;
        b_mag_c   = (bus.sign && bus.b[WIDTH-1]) ? neg(bus.b) : bus.b;
        rem_ext_c = acc_q[2*WIDTH-1:WIDTH-1];
        diff_c    = rem_ext_c - {1'b0, div_q};
        ge_c      = (rem_ext_c >= {1'b0, div_q});
        quo_raw_c = acc_q[WIDTH-1:0];
        rem_raw_c = acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        div_d     = div_q;
        special_d = special_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.kill) begin
                    negq_d = bus.sign && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    negr_d = bus.sign && bus.a[WIDTH-1];
                    div_d  = b_mag_c;
                    if (bus.b == ZERO) begin
                        special_d = 1'b1;
                        acc_d     = {bus.a, ONES};
                        state_d   = S_FIN;
                    end else if (bus.sign && (bus.a == MIN) && (bus.b == ONES)) begin
                        special_d = 1'b1;
                        acc_d     = {ZERO, bus.a};
                        state_d   = S_FIN;
                    end else begin
                        special_d = 1'b0;
                        acc_d     = {ZERO, a_mag_c};
                        cnt_d     = CNT_W'(WIDTH);
                        state_d   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = {(ge_c ? diff_c[WIDTH-1:0] : rem_ext_c[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], ge_c};
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                if (!bus.kill) begin
                    quo_d  = (!special_q && negq_q) ? neg(quo_raw_c) : quo_raw_c;
                    rem_d  = (!special_q && negr_q) ? neg(rem_raw_c) : rem_raw_c;
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            div_q     <= '0;
            special_q <= 1'b0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            div_q     <= div_d;
            special_q <= special_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random bench for seq_divider (WIDTH=32) with a result scoreboard.
module tb_seq_divider;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   done_seen;
    logic prev_done;
    exp_t sb[$];

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // done must be a single-cycle pulse
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_seen++;
            checks++;
            assert (prev_done !== 1'b1) else begin
                errors++;
                $error("FAIL done_pulse got two consecutive done cycles expected single pulse");
            end
        end
        prev_done = bus.done;
    end

    function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sa;
        int   sbv;
        sa  = $signed(a);
        sbv = $signed(b);
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.lat = 1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a; e.r = 32'd0; e.lat = 1;
        end else if (s) begin
            e.q = 32'(sa / sbv); e.r = 32'(sa % sbv); e.lat = 33;
        end else begin
            e.q = a / b; e.r = a % b; e.lat = 33;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive a request and return just after the edge that accepted it.
    task automatic accept(input logic s, input logic [31:0] a, input logic [31:0] b);
        int n;
        bus.start = 1'b1; bus.kill = 1'b0; bus.sign = s; bus.a = a; bus.b = b;
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        assert (bus.ready === 1'b1) else begin
            errors++;
            $error("FAIL ready_wait got=%b expected=1", bus.ready);
        end
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        checks++;
        assert (bus.done === 1'b1) else begin
            errors++;
            $error("FAIL %s_timeout got no done expected done within 100 cycles", tag);
        end
        if (bus.done === 1'b1) begin
            chk({tag, "_q"}, bus.quotient, e.q);
            chk({tag, "_r"}, bus.remainder, e.r);
            chk({tag, "_lat"}, 32'(n), 32'(e.lat));
        end
    endtask

    task automatic do_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
        accept(s, a, b);
        sb.push_back(model(s, a, b));
        wait_done(tag);
    endtask

    initial begin
        logic [31:0] q_prev;
        logic [31:0] r_prev;
        int          d_prev;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        checks = 0; errors = 0; done_seen = 0; prev_done = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0; bus.kill = 1'b0; bus.sign = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_q", bus.quotient, 32'd0);
        chk("rst_r", bus.remainder, 32'd0);

        do_op("s7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        do_op("u_ff_16", 1'b0, 32'hFFFF_FFFF, 32'h10);
        do_op("s_m1_16", 1'b1, 32'hFFFF_FFFF, 32'h10);
        do_op("u_div0", 1'b0, 32'h1234_5678, 32'd0);
        do_op("s_div0", 1'b1, 32'h1234_5678, 32'd0);
        do_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

        // kill mid-calculation keeps previous results
        q_prev = bus.quotient; r_prev = bus.remainder;
        accept(1'b0, 32'd100, 32'd7);
        repeat (10) tick();
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        chk("kill_ready", 32'(bus.ready), 32'd1);
        chk("kill_done", 32'(bus.done), 32'd0);
        d_prev = done_seen;
        repeat (40) tick();
        chk("kill_no_done", 32'(done_seen), 32'(d_prev));
        chk("kill_q", bus.quotient, q_prev);
        chk("kill_r", bus.remainder, r_prev);

        // reset mid-calculation clears everything
        accept(1'b0, 32'd100, 32'd7);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_ready", 32'(bus.ready), 32'd1);
        chk("rstmid_done", 32'(bus.done), 32'd0);
        chk("rstmid_q", bus.quotient, 32'd0);
        chk("rstmid_r", bus.remainder, 32'd0);
        do_op("u100_7", 1'b0, 32'd100, 32'd7);

        // kill wins over start in IDLE
        tick();
        bus.start = 1'b1; bus.kill = 1'b1; bus.sign = 1'b0; bus.a = 32'd9; bus.b = 32'd2;
        tick();
        bus.start = 1'b0; bus.kill = 1'b0;
        chk("idle_kill_ready", 32'(bus.ready), 32'd1);

        // start held high while busy: later operands ignored until the current op completes
        bus.start = 1'b1; bus.sign = 1'b0; bus.a = 32'd1000; bus.b = 32'd3;
        tick();
        sb.push_back(model(1'b0, 32'd1000, 32'd3));
        bus.sign = 1'b1; bus.a = 32'hFFFF_FF9C; bus.b = 32'd7;
        chk("held_busy", 32'(bus.ready), 32'd0);
        wait_done("held_first");
        tick();
        sb.push_back(model(1'b1, 32'hFFFF_FF9C, 32'd7));
        bus.start = 1'b0;
        chk("held_accept", 32'(bus.ready), 32'd0);
        wait_done("held_second");

        // random regression with boundary operands mixed in
        for (int i = 0; i < 250; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = 32'hFFFF_FFFF;
                4: ra = 32'h8000_0000;
                5: rb = ra;
                default: ;
            endcase
            do_op("rand", rs, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
